// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back/write-allocate D-cache controller; define DCACHE_STATS_EN to add hit/miss counters
module dcache_ctrl #(
    parameter int LINES = 32,
    parameter int TAG_W = 22
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         p1_req_i,
    input  logic         p1_write_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [31:0]  p1_data_i,
    output logic [31:0]  p1_data_o,
    output logic         p1_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
`endif
);
    localparam int IDX_W = $clog2(LINES);
    typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, READMISS, READMISSOK} state_t;
    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q [LINES];
    logic [TAG_W-1:0]   tag_d [LINES];
    logic [255:0]       data_q [LINES];
    logic [255:0]       data_d [LINES];
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [255:0]       wb_data_q, wb_data_d;
    logic [TAG_W-1:0]   p1_tag;
    logic [IDX_W-1:0]   p1_idx;
    logic [2:0]         p1_word;
    logic               hit;
    logic               unused_addr;
    always_comb begin
        p1_tag      = p1_addr_i[31 -: TAG_W];
        p1_idx      = p1_addr_i[5 +: IDX_W];
        p1_word     = p1_addr_i[4:2];
        unused_addr = ^p1_addr_i[1:0];
        hit         = valid_q[p1_idx] && (tag_q[p1_idx] == p1_tag);
        p1_stall_o  = p1_req_i && !hit;
        p1_data_o   = data_q[p1_idx][{p1_word, 5'b0} +: 32];
    end
    always_comb begin
        state_d    = state_q;
        miss_tag_d = miss_tag_q;
        idx_d      = idx_q;
        wb_data_d  = wb_data_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        tag_d      = tag_q;
        data_d     = data_q;
        case (state_q)
            IDLE: if (p1_req_i && !hit) begin
                state_d    = MISS;
                miss_tag_d = p1_tag;
                idx_d      = p1_idx;
            end
            MISS: begin
                state_d   = (valid_q[idx_q] && dirty_q[idx_q]) ? WRITEBACK : READMISS;
                wb_data_d = data_q[idx_q];
            end
            WRITEBACK: state_d = mem_ack_i ? READMISS : WRITEBACK;
            READMISS:  state_d = mem_ack_i ? READMISSOK : READMISS;
            default:   state_d = IDLE;
        endcase
        // array writes are suppressed while reset is asserted, even on a coincident ack
        if (rst_i && p1_req_i && p1_write_i && hit) begin
            data_d[p1_idx][{p1_word, 5'b0} +: 32] = p1_data_i;
            dirty_d[p1_idx] = 1'b1;
        end
        if (rst_i && state_q == READMISS && mem_ack_i) begin
            data_d[idx_q]  = mem_data_i;
            tag_d[idx_q]   = miss_tag_q;
            valid_d[idx_q] = 1'b1;
            dirty_d[idx_q] = 1'b0;
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            miss_tag_q <= '0;
            idx_q      <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            miss_tag_q <= miss_tag_d;
            idx_q      <= idx_d;
            wb_data_q  <= wb_data_d;
        end
    end
    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
    always_comb begin
        mem_enable_o = (state_q == WRITEBACK) || (state_q == READMISS);
        mem_write_o  = state_q == WRITEBACK;
        mem_addr_o   = (state_q == WRITEBACK) ? {tag_q[idx_q], idx_q, 5'b0} :
                       (state_q == READMISS)  ? {miss_tag_q, idx_q, 5'b0} : '0;
        mem_data_o   = (state_q == WRITEBACK) ? wb_data_q : '0;
    end
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    always_comb begin
        hit_cnt_d  = hit_cnt_q + 32'((state_q == IDLE) && p1_req_i && hit);
        miss_cnt_d = miss_cnt_q + 32'((state_q == IDLE) && p1_req_i && !hit);
        hit_cnt_o  = hit_cnt_q;
        miss_cnt_o = miss_cnt_q;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed vectors, multi-cycle miss sequences and random traffic against a flat-memory model
module tb_dcache_ctrl;
    logic         clk = 1'b0;
    logic         rst_i;
    logic         p1_req_i, p1_write_i;
    logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
    logic         p1_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif
    int n_chk = 0;
    int n_err = 0;
    logic [255:0] back [logic [31:0]];
    logic [31:0]  gold [logic [31:0]];

    typedef struct {
        logic        req;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_stall;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs [8];

    dcache_ctrl dut (
        .clk_i(clk), .rst_i(rst_i),
        .p1_req_i(p1_req_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
        .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_STATS_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = (la * 32'h0001_0003) ^ (32'(w) * 32'h0101_0101) ^ 32'h5A5A_0000;
        return l;
    endfunction
    function automatic logic [255:0] back_get(input logic [31:0] la);
        return back.exists(la) ? back[la] : init_line(la);
    endfunction
    function automatic logic [31:0] gold_get(input logic [31:0] wa);
        logic [255:0] l;
        if (gold.exists(wa)) return gold[wa];
        l = back_get({wa[29:3], 5'b0});
        return l[{wa[2:0], 5'b0} +: 32];
    endfunction
    function automatic logic [255:0] gold_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = gold_get({2'b0, la[31:5], 3'(w)});
        return l;
    endfunction
    function automatic logic [255:0] make_line(input logic [31:0] base, input logic [31:0] w2);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = base + 32'(w);
        l[95:64] = w2;
        return l;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic nxt();
        @(posedge clk);
        #1;
        mem_ack_i = 1'b0;
    endtask
    task automatic smp();
        @(negedge clk);
    endtask
    task automatic drv(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        p1_req_i = r;
        p1_write_i = w;
        p1_addr_i = a;
        p1_data_i = d;
    endtask

    initial begin
        logic [255:0] lin_l, lin_m, lin_n, wb_line;
        logic         r_req, r_wr, busy, in_miss, exp_wb, eh;
        logic [31:0]  r_addr, r_data, wa, la, va;
        logic [1:0]   ri;
        logic [21:0]  rt;
        logic [3:0]   mv, md;
        logic [21:0]  mt [4];
        int           wcnt, exp_hits;
        lin_l = make_line(32'h1000_0000, 32'hCAFE_F00D);
        lin_m = make_line(32'h3000_0000, 32'hBEEF_0002);
        lin_n = make_line(32'h2000_0000, 32'h2000_0002);
        wb_line = lin_l;
        wb_line[127:96] = 32'h1234_5678;
        vecs[0] = '{1'b1, 1'b0, 32'h48, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[1] = '{1'b1, 1'b1, 32'h4C, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h4C, 32'h0, 1'b0, 1'b1, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h1000_0000};
        vecs[4] = '{1'b1, 1'b0, 32'h5C, 32'h0, 1'b0, 1'b1, 32'h1000_0007};
        vecs[5] = '{1'b1, 1'b0, 32'h4B, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 1'b0, 32'h448, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b1, 32'h1000_0001};
        rst_i = 1'b0;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        drv(1'b1, 1'b0, 32'h48, 32'h0);
        nxt();
        nxt();
        smp();
        chk("rst_enable", mem_enable_o, 0);
        chk("rst_write", mem_write_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_data", mem_data_o, 0);
        chk("rst_stall", p1_stall_o, 1);
        nxt();
        rst_i = 1'b1;
        smp();
        chk("cold_c0_stall", p1_stall_o, 1);
        chk("cold_c0_en", mem_enable_o, 0);
`ifdef DCACHE_STATS_EN
        chk("rst_hit_cnt", hit_cnt_o, 0);
        chk("rst_miss_cnt", miss_cnt_o, 0);
`endif
        nxt();
        smp();
        chk("cold_c1_en", mem_enable_o, 0);
        chk("cold_c1_stall", p1_stall_o, 1);
        for (int c = 2; c <= 5; c++) begin
            nxt();
            smp();
            chk("cold_en", mem_enable_o, 1);
            chk("cold_write", mem_write_o, 0);
            chk("cold_addr", mem_addr_o, 32'h40);
            chk("cold_stall", p1_stall_o, 1);
        end
        mem_ack_i = 1'b1;
        mem_data_i = lin_l;
        nxt();
        smp();
        chk("cold_c6_stall", p1_stall_o, 0);
        chk("cold_c6_data", p1_data_o, 32'hCAFE_F00D);
        chk("cold_c6_en", mem_enable_o, 0);
        nxt();
        exp_hits = 0;
        for (int i = 0; i < 8; i++) begin
            drv(vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            smp();
            chk($sformatf("vec%0d_stall", i), p1_stall_o, vecs[i].exp_stall);
            if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), p1_data_o, vecs[i].exp_data);
            if (vecs[i].req) exp_hits++;
            nxt();
        end
        drv(1'b1, 1'b0, 32'h448, 32'h0);
        smp();
        chk("dirty_c0_stall", p1_stall_o, 1);
        nxt();
        smp();
        chk("dirty_c1_en", mem_enable_o, 0);
        nxt();
        smp();
        chk("wb_en", mem_enable_o, 1);
        chk("wb_write", mem_write_o, 1);
        chk("wb_addr", mem_addr_o, 32'h40);
        chk("wb_word3", mem_data_o[127:96], 32'h1234_5678);
        chk("wb_line", mem_data_o, wb_line);
        nxt();
        smp();
        chk("wb_hold_addr", mem_addr_o, 32'h40);
        mem_ack_i = 1'b1;
        nxt();
        smp();
        chk("rm_en", mem_enable_o, 1);
        chk("rm_write", mem_write_o, 0);
        chk("rm_addr", mem_addr_o, 32'h440);
        chk("rm_data_o", mem_data_o, 0);
        for (int c = 0; c < 20; c++) begin
            nxt();
            smp();
            chk("delay_en", mem_enable_o, 1);
            chk("delay_stall", p1_stall_o, 1);
            chk("delay_addr", mem_addr_o, 32'h440);
        end
        mem_ack_i = 1'b1;
        mem_data_i = lin_m;
        nxt();
        smp();
        chk("dirty_ok_stall", p1_stall_o, 0);
        chk("dirty_ok_data", p1_data_o, 32'hBEEF_0002);
        nxt();
        smp();
        chk("dirty_idle_stall", p1_stall_o, 0);
`ifdef DCACHE_STATS_EN
        chk("stats_miss_cnt", miss_cnt_o, 2);
        chk("stats_hit_cnt", hit_cnt_o, 32'(exp_hits));
`endif
        nxt();
        drv(1'b1, 1'b0, 32'h848, 32'h0);
        smp();
        chk("rr_c0_stall", p1_stall_o, 1);
        nxt();
        nxt();
        smp();
        chk("rr_en", mem_enable_o, 1);
        chk("rr_write", mem_write_o, 0);
        chk("rr_addr", mem_addr_o, 32'h840);
        rst_i = 1'b0;
        mem_ack_i = 1'b1;
        mem_data_i = {8{32'h5555_5555}};
        nxt();
        smp();
        chk("rr_after_en", mem_enable_o, 0);
        chk("rr_after_addr", mem_addr_o, 0);
        chk("rr_after_stall", p1_stall_o, 1);
        nxt();
        rst_i = 1'b1;
        drv(1'b1, 1'b0, 32'h48, 32'h0);
        smp();
        chk("reload_stall", p1_stall_o, 1);
        nxt();
        nxt();
        smp();
        chk("reload_en", mem_enable_o, 1);
        chk("reload_write", mem_write_o, 0);
        chk("reload_addr", mem_addr_o, 32'h40);
        p1_req_i = 1'b0;
        mem_ack_i = 1'b1;
        mem_data_i = lin_n;
        #1;
        chk("noreq_stall", p1_stall_o, 0);
        nxt();
        smp();
        chk("noreq_ok_stall", p1_stall_o, 0);
        chk("noreq_ok_en", mem_enable_o, 0);
        nxt();
        drv(1'b1, 1'b0, 32'h48, 32'h0);
        smp();
        chk("reload_hit_stall", p1_stall_o, 0);
        chk("reload_hit_data", p1_data_o, 32'h2000_0002);
`ifdef DCACHE_STATS_EN
        chk("reload_miss_cnt", miss_cnt_o, 1);
`endif
        rst_i = 1'b0;
        drv(1'b0, 1'b0, 32'h0, 32'h0);
        nxt();
        nxt();
        rst_i = 1'b1;
        gold.delete();
        mv = '0;
        md = '0;
        busy = 1'b0;
        in_miss = 1'b0;
        exp_wb = 1'b0;
        wcnt = 0;
        r_req = 1'b0;
        r_wr = 1'b0;
        r_addr = '0;
        r_data = '0;
        for (int i = 0; i < 4; i++) mt[i] = '0;
        for (int c = 0; c < 4000; c++) begin
            if (!busy) begin
                r_req = $urandom_range(0, 4) != 0;
                r_wr = 1'($urandom_range(0, 1));
                r_addr = {20'b0, 2'($urandom_range(0, 3)), 3'b0, 2'($urandom_range(0, 3)),
                          3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
                r_data = $urandom;
                busy = r_req;
            end
            drv(r_req, r_wr, r_addr, r_data);
            smp();
            ri = r_addr[6:5];
            rt = r_addr[31:10];
            wa = {2'b0, r_addr[31:2]};
            eh = r_req && mv[ri] && (mt[ri] == rt);
            chk("rnd_stall", p1_stall_o, r_req && !eh);
            if (eh) begin
                if (r_wr) begin
                    gold[wa] = r_data;
                    md[ri] = 1'b1;
                end else chk("rnd_load", p1_data_o, gold_get(wa));
                busy = 1'b0;
            end else if (r_req && !in_miss) begin
                in_miss = 1'b1;
                exp_wb = mv[ri] && md[ri];
            end
            if (!in_miss) chk("rnd_spurious_en", mem_enable_o, 0);
            else if (mem_enable_o) begin
                if (wcnt > 0) wcnt--;
                else begin
                    chk("rnd_wb_phase", mem_write_o, exp_wb);
                    if (exp_wb) begin
                        va = {mt[ri], 3'b0, ri, 5'b0};
                        chk("rnd_wb_addr", mem_addr_o, va);
                        chk("rnd_wb_data", mem_data_o, gold_line(va));
                        back[va] = gold_line(va);
                        exp_wb = 1'b0;
                    end else begin
                        la = {rt, 3'b0, ri, 5'b0};
                        chk("rnd_fill_addr", mem_addr_o, la);
                        mem_data_i = back_get(la);
                        mv[ri] = 1'b1;
                        md[ri] = 1'b0;
                        mt[ri] = rt;
                        in_miss = 1'b0;
                    end
                    mem_ack_i = 1'b1;
                    wcnt = $urandom_range(0, 3);
                end
            end
            nxt();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data-cache controller between the MEM stage and the off-chip data memory. It owns the tag and data arrays and the miss state machine. It produces `p1_stall_o`, which freezes the PC and every pipeline register while a miss is being serviced. The core side is single-word, combinational on hit. The memory side is a 256-bit line interface with a one-cycle acknowledge.

## Interface
- `LINES`, 32: number of cache lines; index width is log2(LINES) = 5.
- `TAG_W`, 22: tag width, equal to 32 - 5 index - 5 offset.
- `clk_i`  in  1  system clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `p1_req_i`  in  1  MEM-stage access valid (load or store).
- `p1_write_i`  in  1  1 = store, 0 = load.
- `p1_addr_i`  in  32  byte address. [31:10] tag, [9:5] index, [4:2] word select, [1:0] ignored.
- `p1_data_i`  in  32  store data.
- `p1_data_o`  out  32  load data. Combinational; valid when `p1_req_i & ~p1_stall_o`.
- `p1_stall_o`  out  1  pipeline stall; equals `p1_req_i & ~hit`.
- `mem_enable_o`  out  1  memory request.
- `mem_write_o`  out  1  1 = line write-back, 0 = line fill.
- `mem_addr_o`  out  32  line-aligned address; [4:0] = 0.
- `mem_data_o`  out  256  victim line.
- `mem_data_i`  in  256  fill line.
- `mem_ack_i`  in  1  one-cycle completion pulse.

## Operation
- Per line: valid, dirty, tag[TAG_W], data[256]. Word w occupies bits [32w+31:32w].
- Hit is defined as `valid[idx] & (tag[idx] == p1_addr_i[31:10])`.
- **Load hit:** `p1_data_o` is the selected word in the same cycle.
- **Store hit:** at the clock edge, the selected word is written and dirty is set. This applies in any state.
- **FSM states:** IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
  - IDLE: if `p1_req_i & ~hit`, latch the miss tag and index, then go to MISS.
  - MISS: go to WRITEBACK if the victim is valid and dirty; otherwise go to READMISS.
  - WRITEBACK: on `mem_ack_i`, go to READMISS.
  - READMISS: on `mem_ack_i`, write `mem_data_i` into the line with valid=1, dirty=0 and the latched tag, then go to READMISSOK.
  - READMISSOK: go to IDLE unconditionally.
- **Memory outputs (Moore):**
  - `mem_enable_o` = state ∈ {WRITEBACK, READMISS}.
  - `mem_write_o` = state == WRITEBACK.
  - In WRITEBACK, `mem_addr_o` = {victim tag, idx, 5'b0}.
  - In READMISS, `mem_addr_o` = {latched tag, idx, 5'b0}.
  - `mem_data_o` = the victim line, captured on entry to WRITEBACK.
  - Outside these states, `mem_addr_o` and `mem_data_o` are 0.
- `mem_ack_i` is ignored in IDLE, MISS and READMISSOK.
- **Core-side rule:** the core holds `p1_addr_i`, `p1_write_i` and `p1_data_i` stable while `p1_stall_o` = 1. If the address changes anyway, the latched fill still completes, and hit is re-evaluated in IDLE.

## Timing
- **Reset values:**
  - state = IDLE; all valid and dirty bits = 0.
  - `mem_enable_o` = 0, `mem_write_o` = 0, `mem_addr_o` = 0, `mem_data_o` = 0.
  - `p1_stall_o` = `p1_req_i`, because every access misses after reset.
  - The data array is not cleared.
- **Hit:** zero added latency; stall stays low.
- **Clean miss:** detect in cycle 0. MISS in cycle 1. `mem_enable_o` high from cycle 2 until the ack cycle k. READMISSOK in cycle k+1, where `p1_stall_o` falls and data is valid. The pipeline advances at edge k+2.
- **Dirty miss:** WRITEBACK from cycle 2 until the first ack at cycle j. READMISS from cycle j+1 until the second ack at cycle k. READMISSOK at k+1. `mem_enable_o` stays high continuously from 2 to k; `mem_write_o` falls at j+1.
- **Reset mid-miss:** the FSM returns to IDLE and `mem_enable_o` goes to 0 at the next edge. No array write occurs, even if `mem_ack_i` arrives in that same cycle.
- **`p1_req_i` deasserted mid-miss:** the fill completes anyway, and stall stays 0.

## Configuration
- `DCACHE_STATS_EN`: when defined, adds two outputs.
  - `hit_cnt_o` (out, 32): increments in IDLE on `p1_req_i & hit`.
  - `miss_cnt_o` (out, 32): increments on each IDLE→MISS transition.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

## Test plan
- **Cold load miss:** after reset, load 0x0000_0048.
  - `p1_stall_o` = 1; `mem_enable_o` = 1 with `mem_write_o` = 0 and `mem_addr_o` = 0x40 from cycle 2.
  - Ack at cycle 5 with word2 = 0xCAFE_F00D, so `p1_data_o` = 0xCAFE_F00D and stall = 0 in cycle 6.
- **Store hit:** store 0x1234_5678 to 0x4C. No stall; the next load of 0x4C returns 0x1234_5678.
- **Dirty eviction:** load 0x448 (index 2, tag 1).
  - WRITEBACK: `mem_write_o` = 1, `mem_addr_o` = 0x40, and `mem_data_o` word3 = 0x1234_5678.
  - After ack, READMISS with `mem_addr_o` = 0x440.
- **Delayed ack:** hold ack off for 20 cycles. `mem_enable_o` and `p1_stall_o` stay high and `mem_addr_o` stays stable throughout.
- **Reset during READMISS:** FSM goes to IDLE, enable = 0 next cycle, and a reload of 0x48 misses again.
- **`DCACHE_STATS_EN`:** after the sequence above, `miss_cnt_o` = 2 and `hit_cnt_o` equals the number of hit cycles counted by the bench model.
